// File: rtl/cpu7_csr_timer_ctrl_pkg.sv
// Shared constants, types and helpers for the CSR timer controller.
//   TIMER_BIT       : width of the TCFG.InitVal field
//   TVAL_W          : counter width ({InitVal, 2'b00})
//   CSR_*           : CSR addresses owned by the block
//   TCFG_*_BIT      : TCFG field positions
//   ST_*            : controller FSM state encodings
package cpu7_csr_timer_ctrl_pkg;

  localparam int unsigned TIMER_BIT = 30;
  localparam int unsigned TVAL_W    = TIMER_BIT + 2;
  localparam int unsigned CSR_AW    = 14;
  localparam int unsigned CSR_DW    = 32;

  localparam logic [CSR_AW-1:0] CSR_TCFG  = 14'h41;
  localparam logic [CSR_AW-1:0] CSR_TVAL  = 14'h42;
  localparam logic [CSR_AW-1:0] CSR_TICLR = 14'h44;

  localparam int unsigned TCFG_EN_BIT       = 0;
  localparam int unsigned TCFG_PERIODIC_BIT = 1;
  localparam int unsigned TCFG_INITVAL_LSB  = 2;
  localparam int unsigned TICLR_CLR_BIT     = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  // Stored TCFG fields; packing order matches the CSR bit layout.
  typedef struct packed {
    logic [TIMER_BIT-1:0] initval;
    logic                 periodic;
    logic                 en;
  } tcfg_t;

  // Extract TCFG fields from a CSR write data word.
  function automatic tcfg_t tcfg_from_wdata(input logic [CSR_DW-1:0] d);
    tcfg_t t;
    t.en       = d[TCFG_EN_BIT];
    t.periodic = d[TCFG_PERIODIC_BIT];
    t.initval  = d[TCFG_INITVAL_LSB +: TIMER_BIT];
    return t;
  endfunction

endpackage

// File: rtl/cpu7_csr_timer.sv
// Down-counter used by the CSR timer controller.
//   clk, resetn   : clock, synchronous active-low reset
//   i_init        : load {i_initval, 2'b00} on this edge
//   i_en          : count enable (decrement / reload / hold at 0)
//   i_periodic    : reload on expiry instead of holding at 0
//   i_initval     : InitVal field
//   o_timeval     : current counter value (registered)
//   o_intr        : expiry, counter at 0 while counting (combinational)
module cpu7_csr_timer
  import cpu7_csr_timer_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_init,
  input  logic                 i_en,
  input  logic                 i_periodic,
  input  logic [TIMER_BIT-1:0] i_initval,
  output logic [TVAL_W-1:0]    o_timeval,
  output logic                 o_intr
);

  logic [TVAL_W-1:0] r_timeval;
  logic [TVAL_W-1:0] w_load_val;
  logic              w_zero;

  assign w_load_val = {i_initval, 2'b00};
  assign w_zero     = (r_timeval == '0);
  // The load cycle never reports expiry, even when the old value is 0.
  assign o_intr     = i_en & ~i_init & w_zero;
  assign o_timeval  = r_timeval;

  // Counter: load, decrement, reload on periodic expiry, else stick at 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_timeval <= '0;
    end else if (i_init) begin
      r_timeval <= w_load_val;
    end else if (i_en) begin
      if (w_zero) begin
        if (i_periodic) begin
          r_timeval <= w_load_val;
        end
      end else begin
        r_timeval <= r_timeval - TVAL_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu7_csr_timer_ctrl.sv
// CSR timer controller: TCFG/TVAL/TICLR registers, arm/run FSM and
// the timer-interrupt pending flag.
//   clk, resetn : clock, synchronous active-low reset
//   csr_wen     : CSR write strobe
//   csr_waddr   : CSR write address
//   csr_wdata   : CSR write data
//   csr_raddr   : CSR read address
//   csr_rdata   : read data (combinational), 0 for unowned addresses
//   csr_hit     : csr_raddr is owned by this block (combinational)
//   timer_int   : timer interrupt pending (registered)
//   tval        : current counter value
module cpu7_csr_timer_ctrl
  import cpu7_csr_timer_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              csr_wen,
  input  logic [CSR_AW-1:0] csr_waddr,
  input  logic [CSR_DW-1:0] csr_wdata,
  input  logic [CSR_AW-1:0] csr_raddr,
  output logic [CSR_DW-1:0] csr_rdata,
  output logic              csr_hit,
  output logic              timer_int,
  output logic [TVAL_W-1:0] tval
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  tcfg_t             r_tcfg;
  tcfg_t             w_tcfg_new;
  logic              r_timer_int;
  logic              w_tcfg_wr;
  logic              w_disable_wr;
  logic              w_ticlr_clr;
  logic              w_cnt_init;
  logic              w_cnt_en;
  logic              w_expire;
  logic [TVAL_W-1:0] w_tval;

  assign w_tcfg_new   = tcfg_from_wdata(csr_wdata);
  assign w_tcfg_wr    = csr_wen && (csr_waddr == CSR_TCFG);
  assign w_disable_wr = w_tcfg_wr && !w_tcfg_new.en;
  assign w_ticlr_clr  = csr_wen && (csr_waddr == CSR_TICLR) && csr_wdata[TICLR_CLR_BIT];

  // Counter controls; a disabling write stops the count on its own edge so
  // tval freezes at the value seen when the write was issued.
  assign w_cnt_init = (r_state == ST_ARM);
  assign w_cnt_en   = ((r_state == ST_ARM) || (r_state == ST_RUN)) && !w_disable_wr;

  cpu7_csr_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .i_init     (w_cnt_init),
    .i_en       (w_cnt_en),
    .i_periodic (r_tcfg.periodic),
    .i_initval  (r_tcfg.initval),
    .o_timeval  (w_tval),
    .o_intr     (w_expire)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; a TCFG write overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARM: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_expire && !r_tcfg.periodic) begin
          w_state_nxt = ST_EXPIRED;
        end
      end
      default: w_state_nxt = r_state;
    endcase
    if (w_tcfg_wr) begin
      w_state_nxt = w_tcfg_new.en ? ST_ARM : ST_IDLE;
    end
  end

  // TCFG storage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tcfg <= '0;
    end else if (w_tcfg_wr) begin
      r_tcfg <= w_tcfg_new;
    end
  end

  // Pending flag: expiry has priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_timer_int <= 1'b0;
    end else if (w_expire) begin
      r_timer_int <= 1'b1;
    end else if (w_ticlr_clr) begin
      r_timer_int <= 1'b0;
    end
  end

  // CSR read mux.
  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    case (csr_raddr)
      CSR_TCFG: begin
        csr_rdata = CSR_DW'(r_tcfg);
        csr_hit   = 1'b1;
      end
      CSR_TVAL: begin
        csr_rdata = CSR_DW'(w_tval);
        csr_hit   = 1'b1;
      end
      CSR_TICLR: begin
        csr_hit   = 1'b1;
      end
      default: begin
        csr_rdata = '0;
        csr_hit   = 1'b0;
      end
    endcase
  end

  assign timer_int = r_timer_int;
  assign tval      = w_tval;

endmodule

// File: tb/tb_cpu7_csr_timer_ctrl.sv
// Directed self-checking bench for cpu7_csr_timer_ctrl.
module tb_cpu7_csr_timer_ctrl;
  import cpu7_csr_timer_ctrl_pkg::*;

  logic              clk;
  logic              resetn;
  logic              csr_wen;
  logic [CSR_AW-1:0] csr_waddr;
  logic [CSR_DW-1:0] csr_wdata;
  logic [CSR_AW-1:0] csr_raddr;
  logic [CSR_DW-1:0] csr_rdata;
  logic              csr_hit;
  logic              timer_int;
  logic [TVAL_W-1:0] tval;

  int n_checks;
  int n_pass;

  cpu7_csr_timer_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .csr_wen   (csr_wen),
    .csr_waddr (csr_waddr),
    .csr_wdata (csr_wdata),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .csr_hit   (csr_hit),
    .timer_int (timer_int),
    .tval      (tval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [CSR_AW-1:0] a, input logic [CSR_DW-1:0] d);
    csr_wen   = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    @(posedge clk);
    #1;
    csr_wen   = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
  endtask

  task automatic rd(input logic [CSR_AW-1:0] a);
    csr_raddr = a;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    resetn    = 1'b0;
    csr_wen   = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_raddr = '0;

    // Reset state
    tick(2);
    resetn = 1'b1;
    chk("rst_tval", tval, 32'd0);
    chk("rst_int", 32'(timer_int), 32'd1 - 32'd1);
    rd(CSR_TCFG);
    chk("rst_tcfg", csr_rdata, 32'd0);
    chk("hit_tcfg", 32'(csr_hit), 32'd1);

    // One-shot, InitVal=3: ARM at cycle 1, tval=12 at 2, 0 at 14, int from 15
    wr(CSR_TCFG, 32'h0000_000D);
    tick(1);
    chk("os_tval_c2", tval, 32'd12);
    rd(CSR_TCFG);
    chk("os_tcfg_rb", csr_rdata, 32'h0000_000D);
    tick(12);
    chk("os_tval_c14", tval, 32'd0);
    chk("os_int_c14", 32'(timer_int), 32'd0);
    tick(1);
    chk("os_int_c15", 32'(timer_int), 32'd1);
    tick(3);
    chk("os_tval_hold", tval, 32'd0);
    chk("os_int_hold", 32'(timer_int), 32'd1);
    rd(CSR_TVAL);
    chk("os_rd_tval", csr_rdata, 32'd0);
    wr(CSR_TICLR, 32'h1);
    chk("os_ticlr", 32'(timer_int), 32'd0);

    // Periodic, InitVal=3: period 13
    wr(CSR_TCFG, 32'h0000_000F);
    tick(1);
    chk("per_tval_c2", tval, 32'd12);
    tick(12);
    chk("per_tval_c14", tval, 32'd0);
    tick(1);
    chk("per_tval_c15", tval, 32'd12);
    chk("per_int_c15", 32'(timer_int), 32'd1);
    tick(12);
    chk("per_tval_c27", tval, 32'd0);
    tick(1);
    chk("per_tval_c28", tval, 32'd12);
    wr(CSR_TICLR, 32'h1);
    chk("per_clr_c29", 32'(timer_int), 32'd0);
    chk("per_tval_c29", tval, 32'd11);
    tick(11);
    chk("per_tval_c40", tval, 32'd0);
    // Clear issued in the expiry cycle: set wins
    wr(CSR_TICLR, 32'h1);
    chk("race_int", 32'(timer_int), 32'd1);
    chk("race_tval", tval, 32'd12);
    wr(CSR_TICLR, 32'h1);
    chk("race_late_clr", 32'(timer_int), 32'd0);

    // Disable mid-count then re-arm
    wr(CSR_TCFG, 32'h0000_000D);
    tick(1);
    chk("dis_tval_c2", tval, 32'd12);
    tick(4);
    chk("dis_tval_c6", tval, 32'd8);
    wr(CSR_TCFG, 32'h0000_000C);
    chk("dis_tval_frz", tval, 32'd8);
    tick(3);
    chk("dis_tval_hold", tval, 32'd8);
    chk("dis_int", 32'(timer_int), 32'd0);
    rd(CSR_TCFG);
    chk("dis_tcfg_rb", csr_rdata, 32'h0000_000C);
    wr(CSR_TCFG, 32'h0000_000D);
    chk("rearm_arm_tval", tval, 32'd8);
    tick(1);
    chk("rearm_tval", tval, 32'd12);

    // Reset mid-count
    tick(6);
    chk("mrst_tval_c8", tval, 32'd6);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    chk("mrst_tval", tval, 32'd0);
    chk("mrst_int", 32'(timer_int), 32'd0);
    rd(CSR_TCFG);
    chk("mrst_tcfg", csr_rdata, 32'd0);
    tick(3);
    chk("mrst_idle_tval", tval, 32'd0);

    // Read/write corners
    rd(CSR_TICLR);
    chk("rd_ticlr", csr_rdata, 32'd0);
    chk("hit_ticlr", 32'(csr_hit), 32'd1);
    wr(CSR_TCFG, 32'h0000_000D);
    tick(1);
    chk("tvw_tval_c2", tval, 32'd12);
    wr(CSR_TVAL, 32'hFFFF_FFFF);
    chk("tvw_ignored", tval, 32'd11);
    rd(14'h40);
    chk("nohit_40", 32'(csr_hit), 32'd0);
    chk("nohit_rdata", csr_rdata, 32'd0);
    rd(CSR_TVAL);
    chk("rd_tval", csr_rdata, 32'd11);
    chk("hit_tval", 32'(csr_hit), 32'd1);

    // InitVal=0 periodic: expiry every cycle
    wr(CSR_TCFG, 32'h0000_0003);
    tick(1);
    chk("iv0_tval", tval, 32'd0);
    chk("iv0_int_first", 32'(timer_int), 32'd0);
    tick(1);
    chk("iv0_int_set", 32'(timer_int), 32'd1);
    wr(CSR_TICLR, 32'h1);
    chk("iv0_clr_loses", 32'(timer_int), 32'd1);
    wr(CSR_TCFG, 32'h0000_0002);
    chk("tcfg_keeps_int", 32'(timer_int), 32'd1);
    wr(CSR_TICLR, 32'h1);
    chk("iv0_final_clr", 32'(timer_int), 32'd0);
    tick(2);
    chk("iv0_idle_int", 32'(timer_int), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu7_csr_timer_ctrl.md
CPU7_CSR_TIMER_CTRL -- requirements
Module: cpu7_csr_timer_ctrl

Interface
REQ-001 SHALL have parameter-free ports; widths come from `TIMER_BIT in defines.vh, with `TIMER_BIT+2 <= 32.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock; resetn  input  1  synchronous active-low reset.
REQ-003 csr_wen  input  1  CSR write strobe, one cycle per write.
REQ-004 csr_waddr  input  14  CSR write address.
REQ-005 csr_wdata  input  32  CSR write data.
REQ-006 csr_raddr  input  14  CSR read address.
REQ-007 csr_rdata  output  32  combinational read data for csr_raddr; 0 when the address is not owned.
REQ-008 csr_hit  output  1  csr_raddr is TCFG, TVAL or TICLR.
REQ-009 timer_int  output  1  timer-interrupt pending (ESTAT.TI source), registered.
REQ-010 tval  output  `TIMER_BIT+2  current counter value.

Function
REQ-011 TCFG (14'h41) layout: bit0 En, bit1 Periodic, bits[`TIMER_BIT+1:2] InitVal; read returns the stored fields, zero-extended.
REQ-012 TVAL (14'h42) SHALL be read-only, returning tval zero-extended; writes SHALL be ignored.
REQ-013 TICLR (14'h44): writing 1 to bit0 SHALL clear timer_int; reads SHALL return 0.
REQ-014 FSM states: IDLE, ARM, RUN, EXPIRED.
REQ-015 A TCFG write with En=1 from any state SHALL go to ARM on the next edge; this includes re-arm mid-count.
REQ-016 A TCFG write with En=0 from any state SHALL go to IDLE; tval SHALL freeze at its current value.
REQ-017 ARM lasts exactly one cycle: counter loads {InitVal,2'b00} on the ARM->RUN edge; no expiry is signalled in ARM.
REQ-018 In RUN, the counter SHALL decrement by 1 per cycle; expiry is tval==0 while in RUN.
REQ-019 On expiry with Periodic=1, the counter SHALL reload {InitVal,2'b00} on the next edge and stay in RUN; period = 4*InitVal+1 cycles.
REQ-020 On expiry with Periodic=0, the FSM SHALL go to EXPIRED; the counter is disabled and holds 0 with no wrap; only a TCFG write leaves EXPIRED.
REQ-021 timer_int SHALL be set on the edge ending an expiry cycle, visible the next cycle, and SHALL hold until cleared via TICLR.
REQ-022 Expiry and a TICLR clear in the same cycle: set SHALL win, so timer_int stays 1.
REQ-023 InitVal=0: load 0, expire on the first RUN cycle; with Periodic=1, expiry SHALL occur every cycle.
REQ-024 A TCFG write does not clear timer_int.
REQ-025 A TCFG write SHALL update the stored fields on the write edge; readback SHALL be visible the next cycle.

Reset
REQ-026 With resetn=0 at a clk edge: TCFG fields=0, FSM=IDLE, timer_int=0, tval=0.
REQ-027 Reset mid-count SHALL abort the count with no interrupt; the block then stays idle until a TCFG write.

Structure
REQ-028 CSR addresses (TCFG/TVAL/TICLR), TCFG bit positions and FSM state encodings SHALL live in defines.vh.
REQ-029 The counter SHALL be one sub-module instance of cpu7_csr_timer.
  - Drive: init=(state==ARM); en=(state==ARM or RUN); periodic=TCFG.Periodic.
  - Use its intr as the expiry signal and its timeval as tval.
REQ-030 The FSM, TCFG register, pending flag and read mux SHALL be in this module.

Verification
REQ-031 One-shot: write TCFG=0x0D at edge 0 -> ARM cycle 1; tval=12 at cycle 2, 0 at cycle 14; timer_int=1 from cycle 15; tval holds 0 thereafter.
REQ-032 Periodic: write TCFG=0x0F -> tval=0 at cycles 14 and 27, 12 at cycles 15 and 28; timer_int=1 from cycle 15.
REQ-033 Clear race: expiry cycle coincides with a TICLR=1 write -> timer_int=1; a TICLR=1 write one cycle later -> timer_int=0.
REQ-034 Disable/re-arm: TCFG=0x0D, then TCFG=0x0C at cycle 6 (tval=8) -> tval holds 8 and no interrupt; TCFG=0x0D again -> tval=12 two cycles later.
REQ-035 Reset mid-count: resetn=0 at cycle 8 -> next cycle tval=0, timer_int=0, csr_rdata(TCFG)=0.
REQ-036 Reads and writes: read TICLR -> 0; write TVAL=0xFFFF_FFFF -> tval unchanged; csr_raddr=14'h40 -> csr_hit=0, csr_rdata=0.
